down_timer: RTL and testbench

- Synchronous, loadable down-counter timer.
- Counts a loaded value down to zero at a prescaled rate and emits a one-cycle expire pulse.
- Optional auto-reload mode.
- Consumes count events where the ripple up-counter produces them; serves as the countdown/timeout source for NPC peripherals and testbench watchdogs.
- Loads through a valid/ready handshake.

---
 rtl/timer_pkg.sv | 12 +
 rtl/down_timer_if.sv | 28 ++
 rtl/tick_prescaler.sv | 29 ++
 rtl/down_timer.sv | 94 +++++++++
 tb/tb_down_timer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the down_timer block: FSM state encoding and default widths.
package timer_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_PRESCALE_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOADED = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage : timer_pkg

// File: rtl/down_timer_if.sv
// Load handshake, run control and status signals of down_timer, bundled for port use.
interface down_timer_if #(
    parameter int WIDTH      = timer_pkg::DEF_WIDTH,
    parameter int PRESCALE_W = timer_pkg::DEF_PRESCALE_W
) ();

    logic                  load_valid;
    logic                  load_ready;
    logic [WIDTH-1:0]      load_value;
    logic                  load_auto;
    logic                  start;
    logic                  stop;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      count;
    logic                  running;
    logic                  expire;

    modport master (
        output load_valid, load_value, load_auto, start, stop, prescale,
        input  load_ready, count, running, expire
    );

    modport slave (
        input  load_valid, load_value, load_auto, start, stop, prescale,
        output load_ready, count, running, expire
    );

endinterface : down_timer_if

// File: rtl/tick_prescaler.sv
// Divides the clock into one tick every prescale+1 enabled cycles; prescale is used live.
module tick_prescaler #(
    parameter int PRESCALE_W = timer_pkg::DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] r_presc_cnt;

    // '>=' rather than '==' so lowering prescale mid-run never strands the counter above it.
    assign tick = enable && (r_presc_cnt >= prescale);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc_cnt <= '0;
        end else if (clear) begin
            r_presc_cnt <= '0;
        end else if (enable) begin
            r_presc_cnt <= tick ? '0 : r_presc_cnt + PRESCALE_W'(1);
        end
    end

endmodule : tick_prescaler

// File: rtl/down_timer.sv
// Loadable down-counter timer with prescaled ticks, stop/resume, one-cycle expire pulse
// and optional auto-reload.
module down_timer
    import timer_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    down_timer_if.slave  bus
);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_auto;
    logic             r_expire;

    logic w_run;
    logic w_load_ready;
    logic w_load_acc;
    logic w_start_go;
    logic w_stop_run;
    logic w_presc_clear;
    logic w_presc_en;
    logic w_tick;

    assign w_run        = (r_state == ST_RUN);
    assign w_load_ready = !w_run;
    assign w_load_acc   = bus.load_valid && w_load_ready;
    assign w_stop_run   = w_run && bus.stop;
    // A load in the same cycle as start takes priority, so start only counts without a load.
    assign w_start_go   = !w_load_acc && bus.start &&
                          ((r_state == ST_LOADED) || (r_state == ST_DONE));

    assign w_presc_clear = w_load_acc || w_start_go || w_stop_run;
    assign w_presc_en    = w_run && !bus.stop;

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_presc_clear),
        .enable   (w_presc_en),
        .prescale (bus.prescale),
        .tick     (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_auto   <= 1'b0;
            r_expire <= 1'b0;
        end else begin
            r_expire <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (bus.stop) begin
                        r_state <= ST_LOADED;
                    end else if (w_tick) begin
                        if (r_count != '0) begin
                            r_count <= r_count - WIDTH'(1);
                        end else begin
                            r_expire <= 1'b1;
                            if (r_auto) r_count <= r_reload;
                            else        r_state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    if (w_load_acc) begin
                        r_count  <= bus.load_value;
                        r_reload <= bus.load_value;
                        r_auto   <= bus.load_auto;
                        r_state  <= ST_LOADED;
                    end else if (w_start_go) begin
                        if (r_state == ST_DONE) r_count <= r_reload;
                        r_state <= ST_RUN;
                    end
                end
            endcase
        end
    end

    assign bus.load_ready = w_load_ready;
    assign bus.count      = r_count;
    assign bus.running    = w_run;
    assign bus.expire     = r_expire;

endmodule : down_timer

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios plus randomized traffic against a
// cycle-level behavioural model.
module tb_down_timer;

    localparam int W  = 8;
    localparam int PW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    down_timer_if #(.WIDTH(W), .PRESCALE_W(PW)) bus ();

    down_timer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: mode plus "cycles waited since the last tick" bookkeeping.
    typedef enum {M_IDLE, M_LOADED, M_RUN, M_DONE} mode_t;
    mode_t m_mode;
    int    m_count, m_reload, m_wait;
    bit    m_auto, m_expire;

    task automatic model_reset();
        m_mode = M_IDLE; m_count = 0; m_reload = 0; m_wait = 0; m_auto = 0; m_expire = 0;
    endtask

    task automatic model_step();
        m_expire = 0;
        if (m_mode != M_RUN) begin
            if (bus.load_valid) begin
                m_count  = int'(bus.load_value);
                m_reload = m_count;
                m_auto   = bus.load_auto;
                m_wait   = 0;
                m_mode   = M_LOADED;
            end else if (bus.start && m_mode == M_LOADED) begin
                m_wait = 0;
                m_mode = M_RUN;
            end else if (bus.start && m_mode == M_DONE) begin
                m_count = m_reload;
                m_wait  = 0;
                m_mode  = M_RUN;
            end
        end else if (bus.stop) begin
            m_wait = 0;
            m_mode = M_LOADED;
        end else if (m_wait >= int'(bus.prescale)) begin
            m_wait = 0;
            if (m_count > 0) m_count = m_count - 1;
            else begin
                m_expire = 1;
                if (m_auto) m_count = m_reload;
                else        m_mode  = M_DONE;
            end
        end else begin
            m_wait = m_wait + 1;
        end
    endtask

    task automatic compare();
        check("count",      bus.count,      m_count);
        check("running",    bus.running,    m_mode == M_RUN);
        check("expire",     bus.expire,     m_expire);
        check("load_ready", bus.load_ready, m_mode != M_RUN);
    endtask

    // One clock: DUT and model both take the edge, outputs compared on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_load(input int v, input bit a);
        bus.load_valid = 1'b1;
        bus.load_value = W'(v);
        bus.load_auto  = a;
        cyc();
        bus.load_valid = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.load_valid = 1'b0; bus.load_value = '0; bus.load_auto = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.prescale = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compare();

        // Asynchronous reset in the middle of a run.
        bus.prescale = PW'(2);
        do_load(5, 0);
        do_start();
        cyc();
        check("rst_pre_count", bus.count, 5);
        check("rst_pre_running", bus.running, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_count", bus.count, 0);
        check("rst_running", bus.running, 0);
        check("rst_expire", bus.expire, 0);
        check("rst_load_ready", bus.load_ready, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Load 3, one-shot, prescale 0: 3,2,1,0 then expire 4 edges after start.
        bus.prescale = '0;
        do_load(3, 0);
        do_start();
        check("t2_start_count", bus.count, 3);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("t2_count", bus.count, (k <= 3) ? 3 - k : 0);
            check("t2_expire", bus.expire, k == 4);
        end
        cyc();
        check("t2_expire_once", bus.expire, 0);
        check("t2_done_running", bus.running, 0);
        check("t2_done_ready", bus.load_ready, 1);

        // Load 2, auto-reload, prescale 1: pulse every 6 cycles.
        bus.prescale = PW'(1);
        do_load(2, 1);
        do_start();
        for (int k = 1; k <= 18; k++) begin
            cyc();
            check("t3_expire", bus.expire, (k % 6) == 0);
            check("t3_running", bus.running, 1);
            if ((k % 6) == 0) check("t3_reload", bus.count, 2);
        end
        bus.stop = 1'b1; cyc(); bus.stop = 1'b0;

        // Stop/resume and a load attempt during RUN.
        bus.prescale = '0;
        do_load(4, 0);
        do_start();
        check("t4_ready_run", bus.load_ready, 0);
        bus.load_valid = 1'b1; bus.load_value = W'(9);
        cyc();
        bus.load_valid = 1'b0;
        cyc();
        check("t4_count_ticks", bus.count, 2);
        bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
        check("t4_hold_count", bus.count, 2);
        check("t4_hold_running", bus.running, 0);
        do_start();
        for (int k = 1; k <= 3; k++) begin
            cyc();
            check("t4_resume_expire", bus.expire, k == 3);
        end

        // load_valid with start in LOADED: load wins.
        do_load(6, 0);
        bus.load_valid = 1'b1; bus.load_value = W'(7); bus.start = 1'b1;
        cyc();
        bus.load_valid = 1'b0; bus.start = 1'b0;
        check("t5_load_wins_count", bus.count, 7);
        check("t5_load_wins_running", bus.running, 0);

        // stop on the expiring tick suppresses the expire.
        do_load(1, 0);
        do_start();
        cyc();
        bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
        check("t5_stop_expire", bus.expire, 0);
        check("t5_stop_running", bus.running, 0);
        cyc();
        check("t5_stop_expire_late", bus.expire, 0);

        // start in IDLE is ignored.
        do_reset();
        do_start();
        check("t5_idle_start", bus.running, 0);

        // Load 0, prescale 3: expire 4 edges after start, and again after restart from DONE.
        bus.prescale = PW'(3);
        do_load(0, 0);
        for (int pass = 0; pass < 2; pass++) begin
            do_start();
            for (int k = 1; k <= 5; k++) begin
                cyc();
                check("t6_expire", bus.expire, k == 4);
                if (k >= 4) check("t6_done", bus.running, 0);
            end
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bus.load_valid = ($urandom_range(7) == 0);
            bus.load_value = W'($urandom_range(6));
            bus.load_auto  = $urandom_range(1);
            bus.start      = ($urandom_range(3) == 0);
            bus.stop       = ($urandom_range(15) == 0);
            if ($urandom_range(31) == 0) bus.prescale = PW'($urandom_range(3));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_down_timer
